coin_dispenser: RTL and testbench

Change/refund coin dispenser driven by the vending FSM's `charge_ind` / `coin_sum` outputs. It takes one refund or change amount in Q1 fixed point (value = yuan × 2) and breaks it into coins greedily, largest first. It drives the coin ejector mechanism one coin at a time through a ready/pulse handshake. It sits between the vending FSM and the physical change hopper, and reports completion, rejection and jam faults back to the top level.

---
 rtl/coin_dispenser_pkg.sv | 38 +++
 rtl/coin_dispenser_coin_select.sv | 31 +++
 rtl/coin_dispenser.sv | 151 +++++++++++++++
 tb/tb_coin_dispenser.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/coin_dispenser_pkg.sv
// Shared coin encoding, Q1 denomination values and the dispenser state encoding.
// Also imported by the vending FSM, so keep the coin codes in sync with it.
package coin_dispenser_pkg;

    localparam logic [1:0] COIN_0P5 = 2'b00;
    localparam logic [1:0] COIN_1   = 2'b01;
    localparam logic [1:0] COIN_5   = 2'b10;
    localparam logic [1:0] COIN_10  = 2'b11;

    localparam logic [5:0] Q1_0P5 = 6'd1;
    localparam logic [5:0] Q1_1   = 6'd2;
    localparam logic [5:0] Q1_5   = 6'd10;
    localparam logic [5:0] Q1_10  = 6'd20;

    localparam int SUM_MAX = 40;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SELECT,
        ST_WAIT,
        ST_PULSE,
        ST_GAP,
        ST_DONE,
        ST_FAULT
    } disp_state_t;

    function automatic logic [5:0] coin_value(input logic [1:0] coin);
        logic [5:0] val;
        case (coin)
            COIN_0P5: val = Q1_0P5;
            COIN_1:   val = Q1_1;
            COIN_5:   val = Q1_5;
            default:  val = Q1_10;
        endcase
        return val;
    endfunction

endpackage

// File: rtl/coin_dispenser_coin_select.sv
// Greedy coin choice: the largest denomination not exceeding the remaining amount.
module coin_select
    import coin_dispenser_pkg::*;
(
    input  logic [5:0] remain,
    output logic [1:0] coin_type,
    output logic [5:0] denom
);

    // fits[k] is set when the coin with code k could be paid out without overshoot;
    // the smallest coin is the fallback, so it needs no flag.
    logic [3:1] fits;

    generate
        for (genvar gi = 1; gi < 4; gi++) begin : g_fits
            assign fits[gi] = (remain >= coin_value(2'(gi)));
        end
    endgenerate

    always_comb begin
        coin_type = COIN_0P5;
        if (fits[3])
            coin_type = COIN_10;
        else if (fits[2])
            coin_type = COIN_5;
        else if (fits[1])
            coin_type = COIN_1;
        denom = coin_value(coin_type);
    end

endmodule

// File: rtl/coin_dispenser.sv
// Change/refund dispenser: breaks a Q1 amount into coins and drives the ejector
// one coin at a time, reporting done, rejected requests and sticky jam faults.
module coin_dispenser #(
    parameter int SUM_MAX = coin_dispenser_pkg::SUM_MAX,
    parameter int PULSE_W = 2,
    parameter int GAP_W   = 2,
    parameter int TIMEOUT = 1000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       charge_req,
    input  logic [5:0] charge_val,
    input  logic       eject_rdy,
    output logic       eject,
    output logic [1:0] eject_val,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic       fault,
    output logic [5:0] remain
);
    import coin_dispenser_pkg::*;

    localparam int WAIT_W = $clog2(TIMEOUT + 1);
    localparam int PG_MAX = (PULSE_W > GAP_W) ? PULSE_W : GAP_W;
    localparam int CNT_W  = $clog2(PG_MAX + 1);
    localparam logic [5:0] SUM_MAX_V = 6'(SUM_MAX);

    disp_state_t       state_reg;
    logic              eject_reg;
    logic [1:0]        eject_val_reg;
    logic              busy_reg;
    logic              done_reg;
    logic              err_reg;
    logic              fault_reg;
    logic [5:0]        remain_reg;
    logic [5:0]        denom_reg;
    logic [WAIT_W-1:0] wait_cnt_reg;
    logic [CNT_W-1:0]  cnt_reg;

    logic [1:0] sel_coin;
    logic [5:0] sel_denom;

    coin_select u_coin_select (
        .remain    (remain_reg),
        .coin_type (sel_coin),
        .denom     (sel_denom)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= ST_IDLE;
            eject_reg     <= 1'b0;
            eject_val_reg <= COIN_0P5;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
            err_reg       <= 1'b0;
            fault_reg     <= 1'b0;
            remain_reg    <= '0;
            denom_reg     <= '0;
            wait_cnt_reg  <= '0;
            cnt_reg       <= '0;
        end else begin
            done_reg <= 1'b0;
            err_reg  <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (charge_req) begin
                        if (charge_val == '0) begin
                            state_reg <= ST_DONE;
                            done_reg  <= 1'b1;
                            busy_reg  <= 1'b1;
                        end else if (charge_val > SUM_MAX_V) begin
                            err_reg <= 1'b1;
                        end else begin
                            remain_reg <= charge_val;
                            busy_reg   <= 1'b1;
                            state_reg  <= ST_SELECT;
                        end
                    end
                end
                ST_SELECT: begin
                    // Coin is frozen here so eject_val cannot move during the pulse.
                    eject_val_reg <= sel_coin;
                    denom_reg     <= sel_denom;
                    wait_cnt_reg  <= '0;
                    state_reg     <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (eject_rdy) begin
                        eject_reg <= 1'b1;
                        cnt_reg   <= '0;
                        state_reg <= ST_PULSE;
                    end else if (wait_cnt_reg == WAIT_W'(TIMEOUT - 1)) begin
                        fault_reg <= 1'b1;
                        state_reg <= ST_FAULT;
                    end else begin
                        wait_cnt_reg <= wait_cnt_reg + WAIT_W'(1);
                    end
                end
                ST_PULSE: begin
                    if (cnt_reg == CNT_W'(PULSE_W - 1)) begin
                        eject_reg  <= 1'b0;
                        remain_reg <= remain_reg - denom_reg;
                        cnt_reg    <= '0;
                        state_reg  <= ST_GAP;
                    end else begin
                        cnt_reg <= cnt_reg + CNT_W'(1);
                    end
                end
                ST_GAP: begin
                    if (cnt_reg == CNT_W'(GAP_W - 1)) begin
                        cnt_reg <= '0;
                        if (remain_reg == '0) begin
                            done_reg  <= 1'b1;
                            state_reg <= ST_DONE;
                        end else begin
                            state_reg <= ST_SELECT;
                        end
                    end else begin
                        cnt_reg <= cnt_reg + CNT_W'(1);
                    end
                end
                ST_DONE: begin
                    busy_reg  <= 1'b0;
                    state_reg <= ST_IDLE;
                end
                ST_FAULT: begin
                    // Jammed: hold everything until reset.
                    state_reg <= ST_FAULT;
                end
                default: begin
                    busy_reg  <= 1'b0;
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    a_no_underflow: assert property (@(posedge clk) disable iff (rst)
        (state_reg == ST_PULSE) |-> (denom_reg <= remain_reg));

    assign eject     = eject_reg;
    assign eject_val = eject_val_reg;
    assign busy      = busy_reg;
    assign done      = done_reg;
    assign err       = err_reg;
    assign fault     = fault_reg;
    assign remain    = remain_reg;

endmodule

// File: tb/tb_coin_dispenser.sv
// Bench for coin_dispenser: table of amounts plus hand-written jam/reset/busy sequences,
// with a coin scoreboard checked by a monitor on every eject pulse.
module tb_coin_dispenser;

    localparam int PULSE_W = 2;
    localparam int GAP_W   = 2;
    localparam int TIMEOUT = 1000;
    localparam int COIN_PERIOD = 2 + PULSE_W + GAP_W;

    logic       clk = 1'b0;
    logic       rst;
    logic       charge_req;
    logic [5:0] charge_val;
    logic       eject_rdy;
    logic       eject;
    logic [1:0] eject_val;
    logic       busy;
    logic       done;
    logic       err;
    logic       fault;
    logic [5:0] remain;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [5:0] val;
        bit         exp_err;
        int         exp_coins;
    } vec_t;

    typedef struct {
        logic [1:0] coin;
        logic [5:0] rem;
    } exp_t;

    exp_t exp_q[$];
    vec_t vecs[10];

    coin_dispenser #(
        .SUM_MAX (40),
        .PULSE_W (PULSE_W),
        .GAP_W   (GAP_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .charge_req (charge_req),
        .charge_val (charge_val),
        .eject_rdy  (eject_rdy),
        .eject      (eject),
        .eject_val  (eject_val),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .fault      (fault),
        .remain     (remain)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Greedy reference: coin codes 00/01/10/11 worth 1/2/10/20 in Q1.
    task automatic push_expected(input logic [5:0] v);
        exp_t e;
        logic [5:0] r = v;
        while (r != 0) begin
            if (r >= 20)      begin e.coin = 2'b11; r = r - 20; end
            else if (r >= 10) begin e.coin = 2'b10; r = r - 10; end
            else if (r >= 2)  begin e.coin = 2'b01; r = r - 2;  end
            else              begin e.coin = 2'b00; r = r - 1;  end
            e.rem = r;
            exp_q.push_back(e);
        end
    endtask

    task automatic send(input logic [5:0] v);
        @(negedge clk);
        charge_val = v;
        charge_req = 1'b1;
        @(negedge clk);
        charge_req = 1'b0;
    endtask

    // Returns the cycle count (request cycle = 0) at which done is seen.
    task automatic wait_done(input int start, output int lat);
        lat = start;
        while (!done && lat < 400) begin
            @(negedge clk);
            lat++;
        end
    endtask

    // Scoreboard monitor: pops one expected coin per eject pulse.
    initial begin
        bit   in_pulse = 1'b0;
        int   width = 0;
        exp_t cur;
        cur.coin = 2'b00;
        cur.rem  = 6'd0;
        forever begin
            @(negedge clk);
            if (rst) begin
                in_pulse = 1'b0;
                width    = 0;
            end else if (eject) begin
                if (!in_pulse) begin
                    in_pulse = 1'b1;
                    width    = 1;
                    if (exp_q.size() == 0) begin
                        chk("unexpected_eject", 1, 0);
                        cur.coin = eject_val;
                        cur.rem  = remain;
                    end else begin
                        cur = exp_q.pop_front();
                        chk("coin_type", int'(eject_val), int'(cur.coin));
                    end
                end else begin
                    width++;
                    chk("coin_stable", int'(eject_val), int'(cur.coin));
                end
            end else if (in_pulse) begin
                in_pulse = 1'b0;
                chk("pulse_width", width, PULSE_W);
                chk("remain_after_coin", int'(remain), int'(cur.rem));
            end
        end
    end

    initial begin
        int lat;

        vecs[0] = '{val: 6'd15, exp_err: 1'b0, exp_coins: 4};
        vecs[1] = '{val: 6'd40, exp_err: 1'b0, exp_coins: 2};
        vecs[2] = '{val: 6'd0,  exp_err: 1'b0, exp_coins: 0};
        vecs[3] = '{val: 6'd41, exp_err: 1'b1, exp_coins: 0};
        vecs[4] = '{val: 6'd63, exp_err: 1'b1, exp_coins: 0};
        vecs[5] = '{val: 6'd1,  exp_err: 1'b0, exp_coins: 1};
        vecs[6] = '{val: 6'd2,  exp_err: 1'b0, exp_coins: 1};
        vecs[7] = '{val: 6'd33, exp_err: 1'b0, exp_coins: 4};
        vecs[8] = '{val: 6'd12, exp_err: 1'b0, exp_coins: 2};
        vecs[9] = '{val: 6'd39, exp_err: 1'b0, exp_coins: 7};

        rst = 1'b1;
        charge_req = 1'b0;
        charge_val = '0;
        eject_rdy = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("reset_eject", int'(eject), 0);
        chk("reset_eject_val", int'(eject_val), 0);
        chk("reset_busy", int'(busy), 0);
        chk("reset_done", int'(done), 0);
        chk("reset_err", int'(err), 0);
        chk("reset_fault", int'(fault), 0);
        chk("reset_remain", int'(remain), 0);

        for (int i = 0; i < 10; i++) begin
            if (!vecs[i].exp_err) push_expected(vecs[i].val);
            send(vecs[i].val);
            if (vecs[i].exp_err) begin
                chk("err_pulse", int'(err), 1);
                chk("err_busy", int'(busy), 0);
                chk("err_remain", int'(remain), 0);
                @(negedge clk);
                chk("err_one_cycle", int'(err), 0);
                $display("vec %0d val=%0d rejected", i, vecs[i].val);
            end else begin
                chk("req_busy", int'(busy), 1);
                chk("req_remain", int'(remain), int'(vecs[i].val));
                wait_done(1, lat);
                chk("done_latency", lat, 1 + vecs[i].exp_coins * COIN_PERIOD);
                chk("done_remain", int'(remain), 0);
                chk("coins_left", exp_q.size(), 0);
                @(negedge clk);
                chk("done_one_cycle", int'(done), 0);
                chk("idle_busy", int'(busy), 0);
                $display("vec %0d val=%0d coins=%0d done_latency=%0d", i, vecs[i].val,
                         vecs[i].exp_coins, lat);
            end
        end

        // Request while busy is ignored; the 15 dispense must finish unchanged.
        push_expected(6'd15);
        send(6'd15);
        repeat (3) @(negedge clk);
        charge_val = 6'd40;
        charge_req = 1'b1;
        @(negedge clk);
        charge_req = 1'b0;
        chk("busy_req_no_err", int'(err), 0);
        chk("busy_req_remain", int'(remain), 5);
        wait_done(5, lat);
        chk("busy_req_latency", lat, 1 + 4 * COIN_PERIOD);
        // Request during the DONE cycle is ignored as well.
        charge_val = 6'd2;
        charge_req = 1'b1;
        @(negedge clk);
        charge_req = 1'b0;
        chk("done_req_busy", int'(busy), 0);
        @(negedge clk);
        chk("done_req_ignored", int'(busy), 0);
        chk("done_req_remain", int'(remain), 0);
        $display("busy/done-cycle requests latency=%0d", lat);

        // Reset in the middle of the second coin.
        push_expected(6'd15);
        send(6'd15);
        repeat (8) @(negedge clk);
        chk("mid_second_coin", int'(eject), 1);
        #1 rst = 1'b1;
        @(negedge clk);
        chk("rst_eject", int'(eject), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_remain", int'(remain), 0);
        rst = 1'b0;
        exp_q.delete();
        $display("reset mid-dispense remain=%0d", remain);

        // Jam: ejector never ready.
        eject_rdy = 1'b0;
        send(6'd4);
        repeat (TIMEOUT) @(negedge clk);
        chk("jam_before_timeout", int'(fault), 0);
        @(negedge clk);
        chk("jam_fault", int'(fault), 1);
        chk("jam_busy", int'(busy), 1);
        chk("jam_remain", int'(remain), 4);
        chk("jam_eject", int'(eject), 0);
        charge_val = 6'd2;
        charge_req = 1'b1;
        @(negedge clk);
        charge_req = 1'b0;
        @(negedge clk);
        chk("jam_req_remain", int'(remain), 4);
        chk("jam_req_err", int'(err), 0);
        repeat (3) @(negedge clk);
        chk("jam_sticky", int'(fault), 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("jam_rst_fault", int'(fault), 0);
        chk("jam_rst_busy", int'(busy), 0);
        chk("jam_rst_remain", int'(remain), 0);
        chk("jam_rst_eject_val", int'(eject_val), 0);
        $display("jam fault cleared by reset");
        eject_rdy = 1'b1;
        repeat (2) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
